// File: rtl/spi_cmd_decoder.sv
// SUMP byte-stream to command assembler: one-byte short opcodes, and long opcodes that carry 4 LSB-first argument bytes.
// Optional inter-byte timeout for partial long commands is enabled with `define CMD_TIMEOUT_EN.
module spi_cmd_decoder #(
  parameter logic [7:0]  NOP_OPCODE     = 8'h7F,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic        cmd_long,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        soft_reset,
  output logic        busy,
  output logic        timeout_abort
);

  typedef enum logic {
    IDLE,
    ARG
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  arg_cnt, arg_cnt_nxt;
  logic [7:0]  op_reg, op_reg_nxt;
  logic [23:0] arg_reg, arg_reg_nxt;

  logic        valid_nxt;
  logic        long_nxt;
  logic [7:0]  opcode_nxt;
  logic [31:0] data_nxt;
  logic        srst_nxt;
  logic        abort_nxt;
  logic        expired;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          abort_reg;

  // Counter value equals (idle cycles - 1), so expiry lands on the TIMEOUT_CYCLES-th idle clock.
  assign expired = (state == ARG) && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tcnt_nxt = '0;
    if (state == ARG && !rx_valid && !expired)
      tcnt_nxt = tcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      abort_reg <= 1'b0;
    end else begin
      tcnt      <= tcnt_nxt;
      abort_reg <= abort_nxt;
    end
  end

  assign timeout_abort = abort_reg;
`else
  assign expired       = 1'b0;
  assign timeout_abort = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    arg_cnt_nxt = arg_cnt;
    op_reg_nxt  = op_reg;
    arg_reg_nxt = arg_reg;
    valid_nxt   = 1'b0;
    long_nxt    = cmd_long;
    opcode_nxt  = cmd_opcode;
    data_nxt    = cmd_data;
    srst_nxt    = 1'b0;
    abort_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[7]) begin
            op_reg_nxt  = rx_data;
            arg_reg_nxt = '0;
            arg_cnt_nxt = '0;
            state_nxt   = ARG;
          end else if (rx_data != NOP_OPCODE) begin
            valid_nxt  = 1'b1;
            long_nxt   = 1'b0;
            opcode_nxt = rx_data;
            data_nxt   = '0;
            srst_nxt   = (rx_data == 8'h00);
          end
        end
      end

      ARG: begin
        if (rx_valid) begin
          unique case (arg_cnt)
            2'd0: arg_reg_nxt[7:0]   = rx_data;
            2'd1: arg_reg_nxt[15:8]  = rx_data;
            2'd2: arg_reg_nxt[23:16] = rx_data;
            // Last lane goes straight to the output register with the stored lanes.
            default: begin
              valid_nxt  = 1'b1;
              long_nxt   = 1'b1;
              opcode_nxt = op_reg;
              data_nxt   = {rx_data, arg_reg};
              state_nxt  = IDLE;
            end
          endcase
          arg_cnt_nxt = arg_cnt + 2'd1;
        end else if (expired) begin
          abort_nxt   = 1'b1;
          arg_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      arg_cnt    <= '0;
      op_reg     <= '0;
      arg_reg    <= '0;
      cmd_valid  <= 1'b0;
      cmd_long   <= 1'b0;
      cmd_opcode <= '0;
      cmd_data   <= '0;
      soft_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      arg_cnt    <= arg_cnt_nxt;
      op_reg     <= op_reg_nxt;
      arg_reg    <= arg_reg_nxt;
      cmd_valid  <= valid_nxt;
      cmd_long   <= long_nxt;
      cmd_opcode <= opcode_nxt;
      cmd_data   <= data_nxt;
      soft_reset <= srst_nxt;
    end
  end

  assign busy = (state == ARG);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed byte sequences plus random byte streams, all checked each cycle against a
// queue-based command model. Timeout scenarios run when CMD_TIMEOUT_EN is defined.
module tb_spi_cmd_decoder;

  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        cmd_valid;
  logic        cmd_long;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        soft_reset;
  logic        busy;
  logic        timeout_abort;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state: a pending long command is an opcode plus a queue of received argument bytes.
  bit          m_in_long;
  logic [7:0]  m_op;
  logic [7:0]  m_args[$];
  int unsigned m_idle;
  bit          m_valid, m_srst, m_abort, m_long;
  logic [7:0]  m_opc;
  logic [31:0] m_data;

  spi_cmd_decoder #(
    .NOP_OPCODE    (8'h7F),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cmd_valid    (cmd_valid),
    .cmd_long     (cmd_long),
    .cmd_opcode   (cmd_opcode),
    .cmd_data     (cmd_data),
    .soft_reset   (soft_reset),
    .busy         (busy),
    .timeout_abort(timeout_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_in_long = 0; m_op = '0; m_args.delete(); m_idle = 0;
    m_valid = 0; m_srst = 0; m_abort = 0; m_long = 0; m_opc = '0; m_data = '0;
  endtask

  task automatic check_all();
    check("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    check("soft_reset", 32'(soft_reset), 32'(m_srst));
    check("timeout_abort", 32'(timeout_abort), 32'(m_abort));
    check("busy", 32'(busy), 32'(m_in_long));
    check("cmd_long", 32'(cmd_long), 32'(m_long));
    check("cmd_opcode", 32'(cmd_opcode), 32'(m_opc));
    check("cmd_data", cmd_data, m_data);
  endtask

  // One clock: drive at the falling edge, advance the model, check all outputs 1 time unit after the rising edge.
  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    m_valid = 0; m_srst = 0; m_abort = 0;
    if (v) begin
      m_idle = 0;
      if (!m_in_long) begin
        if (d[7]) begin
          m_in_long = 1; m_op = d; m_args.delete();
        end else if (d != 8'h7F) begin
          m_valid = 1; m_long = 0; m_opc = d; m_data = '0; m_srst = (d == 8'h00);
        end
      end else begin
        m_args.push_back(d);
        if (m_args.size() == 4) begin
          m_valid = 1; m_long = 1; m_opc = m_op;
          m_data = {m_args[3], m_args[2], m_args[1], m_args[0]};
          m_in_long = 0;
        end
      end
    end else if (m_in_long) begin
`ifdef CMD_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        m_abort = 1; m_in_long = 0; m_idle = 0;
      end
`endif
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check_all();
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic apply_reset(input int unsigned cycles);
    @(negedge clk);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    model_clear();
    check_all();
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    apply_reset(2);

    // Short command
    send(8'h01);
    idle(2);

    // Long commands, LSB first
    send(8'hC0); send(8'hFF); send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    send(8'h81); send(8'h0F); send(8'h00); send(8'h0F); send(8'h00);
    idle(1);

    // NOP filtering in IDLE, but 0x7F is data inside a long command
    for (int unsigned i = 0; i < 20; i++) send(8'h7F);
    send(8'h82); send(8'h7F); send(8'h00); send(8'h00); send(8'h00);
    idle(1);

    // Resynchronisation with zero bytes
    send(8'h81); send(8'h0F);
    for (int unsigned i = 0; i < 5; i++) send(8'h00);
    send(8'h02);
    idle(1);

    // Reset mid-command, then first byte is an opcode
    send(8'hC2); send(8'h00);
    apply_reset(3);
    send(8'h01);
    idle(1);

`ifdef CMD_TIMEOUT_EN
    // Partial command dropped after TMO idle clocks
    send(8'hC1); send(8'h40);
    idle(TMO);
    idle(2);
    send(8'h01);
    idle(1);
    // Byte on the expiry cycle is accepted
    send(8'hC1); send(8'h40);
    idle(TMO - 1);
    send(8'h11); send(8'h22); send(8'h33);
    idle(2);
`endif

    // Random byte stream with mixed gaps
    for (int unsigned i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [7:0]  b;
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'h00;
      else if (r < 3) b = 8'h7F;
      else if (r < 6) b = 8'h80 | 8'($urandom_range(0, 127));
      else            b = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, b);
`ifdef CMD_TIMEOUT_EN
      if ($urandom_range(0, 99) == 0) idle($urandom_range(TMO - 2, TMO + 2));
`endif
      if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
